// File: rtl/riscv_data_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : riscv_data_mem                                             |
// | Description : Word-organised data memory slave for the load/store unit.  |
// |               Programmable wait states, byte-enable write merge and      |
// |               out-of-range error flagging. Returns aligned 32-bit words. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module riscv_data_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  output logic        mem_ready_o,
  output logic        mem_err_o,
  output logic        busy_o
);

  localparam int unsigned IDXW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] c_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  c_WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_wd;
  logic [IDXW-1:0]   r_idx;
  logic              r_inr;
  logic [31:0]       r_rd;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic [31:0]       w_off;
  logic              w_in_range;
  logic [IDXW-1:0]   w_idx;
  logic              w_accept;
  logic              w_enter_ready;
  logic              w_cap_we;
  logic              w_cap_inr;
  logic [IDXW-1:0]   w_cap_idx;
  logic              w_commit;

  // Address decode: offset from the base wraps modulo 2^32, so addresses
  // below BASE_ADDR land far above the limit and are flagged out of range.
  always_comb begin
    w_off      = mem_addr_i - BASE_ADDR;
    w_in_range = ({1'b0, w_off} < c_LIMIT);
    w_idx      = w_off[IDXW+1:2];
  end

  // Capture source: with zero wait states READY is entered on the accepting
  // edge itself, so the live request must be used instead of the latches.
  always_comb begin
    w_accept      = (r_state == S_IDLE) && mem_req_i;
    w_enter_ready = (w_state_nxt == S_READY) && (r_state != S_READY);
    if (r_state == S_IDLE) begin
      w_cap_we  = mem_we_i;
      w_cap_inr = w_in_range;
      w_cap_idx = w_idx;
    end else begin
      w_cap_we  = r_we;
      w_cap_inr = r_inr;
      w_cap_idx = r_idx;
    end
    w_commit = (r_state == S_READY) && r_we && r_inr && mem_req_i;
  end

  // Next-state logic; a dropped request in WAIT abandons the access.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem_req_i) begin
          w_state_nxt = (c_WS == 4'd0) ? S_READY : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!mem_req_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt <= 4'd1) begin
          w_state_nxt = S_READY;
        end
      end
      S_READY: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wait-state counter and latched request fields.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= 4'd0;
      r_we  <= 1'b0;
      r_be  <= 4'd0;
      r_wd  <= 32'd0;
      r_idx <= '0;
      r_inr <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= c_WS;
      r_we  <= mem_we_i;
      r_be  <= mem_be_i;
      r_wd  <= mem_wd_i;
      r_idx <= w_idx;
      r_inr <= w_in_range;
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Read data is sampled on the edge entering READY; writes and errors
  // return zero so stale data never accompanies those completions.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd <= 32'd0;
    end else if (w_enter_ready) begin
      r_rd <= (!w_cap_we && w_cap_inr) ? r_mem[w_cap_idx] : 32'd0;
    end
  end

  // Byte-lane write commit on the edge leaving READY; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wd[8*b +: 8];
        end
      end
    end
  end

  assign mem_rd_o    = r_rd;
  assign mem_ready_o = (r_state == S_READY);
  assign mem_err_o   = (r_state == S_READY) && !r_inr;
  assign busy_o      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_riscv_data_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_riscv_data_mem                                          |
// | Description : Scoreboard bench for riscv_data_mem. Three instances with  |
// |               1, 3 and 0 wait states share one stimulus bus; the active  |
// |               instance is chosen by r_sel.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_riscv_data_mem;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        r_req;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  int          r_sel;

  logic [31:0] w_rd    [3];
  logic        w_rdy   [3];
  logic        w_err   [3];
  logic        w_busy  [3];
  logic        w_reqk  [3];

  exp_t        q_exp[$];
  int          n_cmp;
  int          n_bad;
  int          cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always_comb begin
    w_reqk[0] = r_req && (r_sel == 0);
    w_reqk[1] = r_req && (r_sel == 1);
    w_reqk[2] = r_req && (r_sel == 2);
  end

  riscv_data_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_dut_ws1 (
    .clk_i(clk), .rst_i(rst_n), .mem_req_i(w_reqk[0]), .mem_we_i(r_we),
    .mem_be_i(r_be), .mem_addr_i(r_addr), .mem_wd_i(r_wd),
    .mem_rd_o(w_rd[0]), .mem_ready_o(w_rdy[0]), .mem_err_o(w_err[0]), .busy_o(w_busy[0]));

  riscv_data_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut_ws3 (
    .clk_i(clk), .rst_i(rst_n), .mem_req_i(w_reqk[1]), .mem_we_i(r_we),
    .mem_be_i(r_be), .mem_addr_i(r_addr), .mem_wd_i(r_wd),
    .mem_rd_o(w_rd[1]), .mem_ready_o(w_rdy[1]), .mem_err_o(w_err[1]), .busy_o(w_busy[1]));

  riscv_data_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut_ws0 (
    .clk_i(clk), .rst_i(rst_n), .mem_req_i(w_reqk[2]), .mem_we_i(r_we),
    .mem_be_i(r_be), .mem_addr_i(r_addr), .mem_wd_i(r_wd),
    .mem_rd_o(w_rd[2]), .mem_ready_o(w_rdy[2]), .mem_err_o(w_err[2]), .busy_o(w_busy[2]));

  function automatic int ws_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 3 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every ready pulse on any instance must match the queue head.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (w_rdy[k] === 1'b1) begin
        if (q_exp.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ready: dut %0d rd %h err %b at cycle %0d", k, w_rd[k], w_err[k], cyc);
        end else begin
          exp_t e;
          e = q_exp.pop_front();
          check("ready_dut", 32'(k), 32'(r_sel));
          check("rd", w_rd[k], e.rd);
          check("err", {31'd0, w_err[k]}, {31'd0, e.err});
          check("ready_cycle", 32'(cyc), 32'(e.cyc));
          check("busy_in_ready", {31'd0, w_busy[k]}, 32'd1);
        end
      end
    end
  end

  // Issues one access starting just after a rising edge; returns just after
  // the edge that follows the ready pulse, with req still high if keep is set.
  task automatic access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input logic keep);
    exp_t e;
    bit   seen;
    r_req  = 1'b1;
    r_we   = we;
    r_be   = be;
    r_addr = addr;
    r_wd   = wd;
    e.rd   = exp_rd;
    e.err  = exp_err;
    e.cyc  = cyc + 1 + ws_of(r_sel);
    q_exp.push_back(e);
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (w_rdy[r_sel] === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: addr %h no ready within 40 cycles", addr);
      void'(q_exp.pop_front());
    end
    @(posedge clk);
    #1;
    if (!keep) r_req = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    cyc    = 0;
    r_sel  = 0;
    r_req  = 1'b0;
    r_we   = 1'b0;
    r_be   = 4'h0;
    r_addr = 32'h0;
    r_wd   = 32'h0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: all outputs remain zero.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", {w_rd[0][30:0] | w_rd[0][31:31], w_rdy[0]} | {31'd0, w_err[0] | w_busy[0]}, 32'd0);
    end
    @(posedge clk);
    #1;

    // One wait state: word write/read, byte merges, range checks.
    access(1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
    access(1'b0, 4'hF, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
    access(1'b1, 4'h4, 32'h10,   32'h55555555, 32'h0,        1'b0, 1'b0);
    access(1'b0, 4'hF, 32'h10,   32'h0,        32'hDE55BEEF, 1'b0, 1'b0);
    access(1'b1, 4'h3, 32'h10,   32'h12341234, 32'h0,        1'b0, 1'b0);
    access(1'b0, 4'hF, 32'h10,   32'h0,        32'hDE551234, 1'b0, 1'b0);
    access(1'b1, 4'hF, 32'h0,    32'hCAFEF00D, 32'h0,        1'b0, 1'b0);
    access(1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0);
    access(1'b0, 4'hF, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0, 1'b0);
    access(1'b0, 4'hF, 32'h1000, 32'h0,        32'h0,        1'b1, 1'b0);
    access(1'b1, 4'h0, 32'h10,   32'hFFFFFFFF, 32'h0,        1'b0, 1'b0);
    access(1'b0, 4'hF, 32'h10,   32'h0,        32'hDE551234, 1'b0, 1'b0);
    access(1'b0, 4'hF, 32'h3FFC, 32'h0,        32'h0,        1'b1, 1'b0);

    // Three wait states: abort in WAIT, then reset during a write's READY.
    r_sel = 1;
    access(1'b1, 4'hF, 32'h20, 32'h0BADF00D, 32'h0,        1'b0, 1'b0);
    access(1'b0, 4'hF, 32'h20, 32'h0,        32'h0BADF00D, 1'b0, 1'b0);
    r_req = 1'b1; r_we = 1'b1; r_be = 4'hF; r_addr = 32'h20; r_wd = 32'h99999999;
    @(posedge clk);
    @(posedge clk);
    #1 r_req = 1'b0;
    @(negedge clk);
    check("busy_before_abort_edge", {31'd0, w_busy[1]}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("busy_after_abort", {31'd0, w_busy[1]}, 32'd0);
    access(1'b0, 4'hF, 32'h20, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);

    begin
      exp_t e;
      bit   seen;
      r_req = 1'b1; r_we = 1'b1; r_be = 4'hF; r_addr = 32'h20; r_wd = 32'h77777777;
      e.rd = 32'h0; e.err = 1'b0; e.cyc = cyc + 4;
      q_exp.push_back(e);
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
        @(negedge clk);
        if (w_rdy[1] === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ready_timeout: reset-in-ready write never reached READY");
        void'(q_exp.pop_front());
      end
      #1 rst_n = 1'b0;
      #1;
      check("rst_ready", {31'd0, w_rdy[1]}, 32'd0);
      check("rst_busy",  {31'd0, w_busy[1]}, 32'd0);
      check("rst_err",   {31'd0, w_err[1]}, 32'd0);
      check("rst_rd",    w_rd[1], 32'd0);
      r_req = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
    end
    access(1'b0, 4'hF, 32'h20, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);

    // Zero wait states: back-to-back accesses two cycles apart.
    r_sel = 2;
    access(1'b1, 4'hF, 32'h0, 32'h11111111, 32'h0,        1'b0, 1'b1);
    access(1'b1, 4'hF, 32'h4, 32'h22222222, 32'h0,        1'b0, 1'b1);
    access(1'b0, 4'hF, 32'h0, 32'h0,        32'h11111111, 1'b0, 1'b1);
    access(1'b0, 4'hF, 32'h4, 32'h0,        32'h22222222, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 32'(q_exp.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
